tx_align_pattern_gen: RTL and testbench

//  Transmit-side partner of the receiver IDELAY alignment controller. Drives the 8-bit parallel

---
 rtl/tx_align_pattern_gen_pkg.sv | 12 +
 rtl/tx_align_pattern_gen_if.sv | 8 +
 rtl/tx_align_pattern_gen_prbs7.sv | 17 +
 rtl/tx_align_pattern_gen.sv | 133 +++++++++++++
 tb/tb_tx_align_pattern_gen.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/tx_align_pattern_gen_pkg.sv
// tx_align_pattern_gen_pkg: shared state encodings and link constants
package tx_align_pattern_gen_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRAIN = 3'd1,
        ST_HOLD  = 3'd2,
        ST_GUARD = 3'd3,
        ST_DATA  = 3'd4
    } state_t;
    localparam logic [6:0] PRBS_SEED     = 7'h7F;
    localparam logic [7:0] IDLE_WORD_DEF = 8'hAC;
endpackage

// File: rtl/tx_align_pattern_gen_if.sv
// tx_align_pattern_gen_if: user word valid/ready handshake
interface tx_align_pattern_gen_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tx_align_pattern_gen_prbs7.sv
// prbs7_par8: x^7+x^6+1 Fibonacci LFSR advanced 8 bits, first bit lands in word[7]
module prbs7_par8 (
    input  logic [6:0] state,
    output logic [7:0] word,
    output logic [6:0] next_state
);
    logic [6:0] s;
    always_comb begin
        s = state;
        word = '0;
        for (int i = 7; i >= 0; i--) begin
            word[i] = s[6] ^ s[5];
            s = {s[5:0], s[6] ^ s[5]};
        end
        next_state = s;
    end
endmodule

// File: rtl/tx_align_pattern_gen.sv
// tx_align_pattern_gen: PRBS7 training, guard idles and user data toward the OSERDES
module tx_align_pattern_gen
    import tx_align_pattern_gen_pkg::*;
#(
    parameter logic [7:0]  IDLE_WORD     = IDLE_WORD_DEF,
    parameter int          LOCK_HOLD     = 16,
    parameter int          GUARD_WORDS   = 8,
    parameter logic [19:0] TRAIN_TIMEOUT = 20'hFFFFF
) (
    input  logic                         clk160,
    input  logic                         totalCounterResetb_manual,
    input  logic                         enable,
    input  logic                         train_req,
    input  logic                         rx_delay_ready,
    tx_align_pattern_gen_if.slave        tx,
    output logic [7:0]                   d_out,
    output logic                         training_active,
    output logic                         link_up,
    output logic [15:0]                  words_sent,
    output logic [7:0]                   train_timeouts
);
    localparam int HW = $clog2(LOCK_HOLD + 1);
    localparam int GW = $clog2(GUARD_WORDS + 1);
    state_t        state, state_n;
    logic [6:0]    prbs, prbs_n, prbs_next;
    logic [7:0]    prbs_word, d_n, to_n;
    logic [19:0]   train_cnt, train_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [GW-1:0] guard_cnt, guard_n;
    logic [15:0]   words_n;
    logic          rq_s1, rq_s2, rq_prev, rdy_s1, rdy_s;
    logic          train_req_rise, accept;

    prbs7_par8 u_prbs (.state(prbs), .word(prbs_word), .next_state(prbs_next));

    assign train_req_rise  = rq_s2 && !rq_prev;
    assign tx.tx_ready     = (state == ST_DATA) && enable && !train_req_rise;
    assign accept          = tx.tx_valid && tx.tx_ready;
    assign training_active = (state == ST_TRAIN) || (state == ST_HOLD);
    assign link_up         = (state == ST_GUARD) || (state == ST_DATA);

    always_comb begin
        state_n = state;
        prbs_n  = prbs;
        train_n = train_cnt;
        hold_n  = hold_cnt;
        guard_n = guard_cnt;
        d_n     = IDLE_WORD;
        words_n = words_sent;
        to_n    = train_timeouts;
        if (!enable) begin
            state_n = ST_IDLE;
        end else if (train_req_rise && state != ST_IDLE) begin
            state_n = ST_TRAIN;
            train_n = '0;
            prbs_n  = PRBS_SEED;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_TRAIN;
                    train_n = '0;
                    prbs_n  = PRBS_SEED;
                end
                ST_TRAIN: begin
                    d_n     = prbs_word;
                    prbs_n  = prbs_next;
                    train_n = train_cnt + 20'd1;
                    if (rdy_s) begin
                        state_n = ST_HOLD;
                        hold_n  = '0;
                    end else if (train_cnt == TRAIN_TIMEOUT - 20'd1) begin
                        to_n    = train_timeouts + {7'd0, train_timeouts != 8'hFF};
                        prbs_n  = PRBS_SEED;
                        train_n = '0;
                    end
                end
                ST_HOLD: begin
                    d_n    = prbs_word;
                    prbs_n = prbs_next;
                    if (!rdy_s) begin
                        state_n = ST_TRAIN;
                    end else if (hold_cnt == HW'(LOCK_HOLD - 1)) begin
                        state_n = ST_GUARD;
                        guard_n = '0;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                ST_GUARD: begin
                    state_n = (guard_cnt == GW'(GUARD_WORDS - 1)) ? ST_DATA : ST_GUARD;
                    guard_n = guard_cnt + GW'(1);
                end
                ST_DATA: begin
                    d_n     = accept ? tx.tx_data : IDLE_WORD;
                    words_n = words_sent + {15'd0, accept && words_sent != 16'hFFFF};
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
        if (!totalCounterResetb_manual) begin
            rq_s1          <= 1'b0;
            rq_s2          <= 1'b0;
            rq_prev        <= 1'b0;
            rdy_s1         <= 1'b0;
            rdy_s          <= 1'b0;
            state          <= ST_IDLE;
            prbs           <= PRBS_SEED;
            train_cnt      <= '0;
            hold_cnt       <= '0;
            guard_cnt      <= '0;
            d_out          <= IDLE_WORD;
            words_sent     <= '0;
            train_timeouts <= '0;
        end else begin
            rq_s1          <= train_req;
            rq_s2          <= rq_s1;
            rq_prev        <= rq_s2;
            rdy_s1         <= rx_delay_ready;
            rdy_s          <= rdy_s1;
            state          <= state_n;
            prbs           <= prbs_n;
            train_cnt      <= train_n;
            hold_cnt       <= hold_n;
            guard_cnt      <= guard_n;
            d_out          <= d_n;
            words_sent     <= words_n;
            train_timeouts <= to_n;
        end
    end
endmodule

// File: tb/tb_tx_align_pattern_gen.sv
// tb_tx_align_pattern_gen: directed checks of training, lock hold, guard, data and timeouts
module tb_tx_align_pattern_gen;
    logic        clk160 = 1'b0;
    logic        rstn = 1'b0;
    logic        en0 = 1'b0, en1 = 1'b0, treq = 1'b0, rdy = 1'b0;
    logic [7:0]  d0, d1;
    logic        ta0, ta1, lu0, lu1;
    logic [15:0] ws0, ws1;
    logic [7:0]  to0, to1;
    int          checks = 0, errors = 0, widx = 0;
    logic        seq [0:133];

    tx_align_pattern_gen_if i0 ();
    tx_align_pattern_gen_if i1 ();

    tx_align_pattern_gen dut (
        .clk160(clk160), .totalCounterResetb_manual(rstn), .enable(en0), .train_req(treq),
        .rx_delay_ready(rdy), .tx(i0), .d_out(d0), .training_active(ta0), .link_up(lu0),
        .words_sent(ws0), .train_timeouts(to0));

    tx_align_pattern_gen #(.TRAIN_TIMEOUT(20'd32)) dut_to (
        .clk160(clk160), .totalCounterResetb_manual(rstn), .enable(en1), .train_req(1'b0),
        .rx_delay_ready(1'b0), .tx(i1), .d_out(d1), .training_active(ta1), .link_up(lu1),
        .words_sent(ws1), .train_timeouts(to1));

    always #5 clk160 = ~clk160;

    function automatic logic [7:0] ref_word(input int k);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[7-j] = seq[7 + (8 * k + j) % 127];
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk160);
        #1;
    endtask

    task automatic prbs_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("prbs_word", {8'd0, d0}, {8'd0, ref_word(widx)});
            widx++;
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) seq[i] = 1'b1;
        for (int i = 7; i < 134; i++) seq[i] = seq[i-7] ^ seq[i-6];
        i0.tx_data = 8'h00; i0.tx_valid = 1'b0;
        i1.tx_data = 8'h00; i1.tx_valid = 1'b0;
        repeat (3) step();
        check("rst_d_out", {8'd0, d0}, 16'h00AC);
        check("rst_tx_ready", {15'd0, i0.tx_ready}, 16'd0);
        check("rst_training", {15'd0, ta0}, 16'd0);
        check("rst_link_up", {15'd0, lu0}, 16'd0);
        check("rst_words", ws0, 16'd0);
        check("rst_timeouts", {8'd0, to0}, 16'd0);
        rstn = 1'b1;
        step();
        // timeout instance: expiries land on edges 33, 65, 97 after enable
        en1 = 1'b1;
        step();
        check("to_first_idle", {8'd0, d1}, 16'h00AC);
        for (int k = 2; k <= 100; k++) begin
            step();
            if (k == 33) check("to_last_word", {8'd0, d1}, {8'd0, ref_word(31)});
            if (k == 34) check("to_reseed_word", {8'd0, d1}, 16'h0002);
            if (k == 96) check("to_count_96", {8'd0, to1}, 16'd2);
        end
        check("to_count_100", {8'd0, to1}, 16'd3);
        check("disabled_d_out", {8'd0, d0}, 16'h00AC);
        check("disabled_training", {15'd0, ta0}, 16'd0);
        en1 = 1'b0;
        step();
        check("to_disable_idle", {8'd0, d1}, 16'h00AC);
        check("to_disable_training", {15'd0, ta1}, 16'd0);
        check("to_count_kept", {8'd0, to1}, 16'd3);
        // PRBS training stream from seed
        en0 = 1'b1;
        step();
        check("first_idle", {8'd0, d0}, 16'h00AC);
        check("training_active", {15'd0, ta0}, 16'd1);
        step();
        check("prbs_seed_word", {8'd0, d0}, 16'h0002);
        widx = 1;
        prbs_steps(999);
        // partial hold, then loss of ready
        rdy = 1'b1;
        prbs_steps(13);
        rdy = 1'b0;
        prbs_steps(8);
        check("abort_link_up", {15'd0, lu0}, 16'd0);
        check("abort_training", {15'd0, ta0}, 16'd1);
        // full hold needed again
        rdy = 1'b1;
        prbs_steps(18);
        check("hold_15_link_up", {15'd0, lu0}, 16'd0);
        prbs_steps(1);
        check("guard_link_up", {15'd0, lu0}, 16'd1);
        check("guard_training", {15'd0, ta0}, 16'd0);
        check("guard_tx_ready", {15'd0, i0.tx_ready}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("guard_word", {8'd0, d0}, 16'h00AC);
            check("guard_ready", {15'd0, i0.tx_ready}, (i == 7) ? 16'd1 : 16'd0);
        end
        // user data pass-through
        for (int i = 0; i < 256; i++) begin
            i0.tx_data = 8'(i); i0.tx_valid = 1'b1;
            step();
            check("data_word", {8'd0, d0}, 16'(i));
        end
        check("words_256", ws0, 16'd256);
        i0.tx_valid = 1'b0;
        step();
        check("underrun_idle", {8'd0, d0}, 16'h00AC);
        rdy = 1'b0;
        repeat (4) step();
        check("rdy_loss_ignored", {15'd0, lu0}, 16'd1);
        // retrain during DATA
        i0.tx_data = 8'h55; i0.tx_valid = 1'b1; treq = 1'b1;
        step();
        check("pre_rise_word", {8'd0, d0}, 16'h0055);
        step();
        check("rise_tx_ready", {15'd0, i0.tx_ready}, 16'd0);
        treq = 1'b0;
        step();
        check("rejected_words", ws0, 16'd258);
        check("retrain_link_up", {15'd0, lu0}, 16'd0);
        check("retrain_training", {15'd0, ta0}, 16'd1);
        step();
        check("retrain_seed_word", {8'd0, d0}, 16'h0002);
        // back to DATA, then reset mid-word
        rdy = 1'b1; i0.tx_data = 8'h3C;
        repeat (30) step();
        check("relock_link_up", {15'd0, lu0}, 16'd1);
        check("relock_data", {8'd0, d0}, 16'h003C);
        #3 rstn = 1'b0;
        #1;
        check("async_rst_d_out", {8'd0, d0}, 16'h00AC);
        check("async_rst_words", ws0, 16'd0);
        check("async_rst_timeouts", {8'd0, to1}, 16'd0);
        check("async_rst_link_up", {15'd0, lu0}, 16'd0);
        check("async_rst_tx_ready", {15'd0, i0.tx_ready}, 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
